// File: rtl/vip_axis_host_if.sv
// -----------------------------------------------------------------------------
// vip_axis_host_if
//   Bundles the two AXI-Stream channels between the host model and the VIP:
//   h2c (host -> VIP) and c2h (VIP -> host).
//
//   Signals (names kept identical to the VIP's XDMA-style port names):
//     m_axis_h2c_tdata_0  / tlast / tvalid / tkeep : driven by the host
//     m_axis_h2c_tready_0                          : driven by the VIP
//     s_axis_c2h_tdata_0  / tlast / tvalid / tkeep : driven by the VIP
//     s_axis_c2h_tready_0                          : driven by the host
//
//   Modports:
//     master : host side (vip_axis_host)
//     slave  : VIP side (or a testbench standing in for it)
// -----------------------------------------------------------------------------
interface vip_axis_host_if #(
  parameter int C_DATA_WIDTH = 64
);
  // h2c channel
  logic [C_DATA_WIDTH-1:0]   m_axis_h2c_tdata_0;
  logic                      m_axis_h2c_tlast_0;
  logic                      m_axis_h2c_tvalid_0;
  logic                      m_axis_h2c_tready_0;
  logic [C_DATA_WIDTH/8-1:0] m_axis_h2c_tkeep_0;

  // c2h channel
  logic [C_DATA_WIDTH-1:0]   s_axis_c2h_tdata_0;
  logic                      s_axis_c2h_tlast_0;
  logic                      s_axis_c2h_tvalid_0;
  logic                      s_axis_c2h_tready_0;
  logic [C_DATA_WIDTH/8-1:0] s_axis_c2h_tkeep_0;

  modport master (
    output m_axis_h2c_tdata_0,
    output m_axis_h2c_tlast_0,
    output m_axis_h2c_tvalid_0,
    input  m_axis_h2c_tready_0,
    output m_axis_h2c_tkeep_0,
    input  s_axis_c2h_tdata_0,
    input  s_axis_c2h_tlast_0,
    input  s_axis_c2h_tvalid_0,
    output s_axis_c2h_tready_0,
    input  s_axis_c2h_tkeep_0
  );

  modport slave (
    input  m_axis_h2c_tdata_0,
    input  m_axis_h2c_tlast_0,
    input  m_axis_h2c_tvalid_0,
    output m_axis_h2c_tready_0,
    input  m_axis_h2c_tkeep_0,
    output s_axis_c2h_tdata_0,
    output s_axis_c2h_tlast_0,
    output s_axis_c2h_tvalid_0,
    input  s_axis_c2h_tready_0,
    output s_axis_c2h_tkeep_0
  );
endinterface

// File: rtl/vip_axis_host.sv
// -----------------------------------------------------------------------------
// vip_axis_host
//   Host-side counterpart of the AXI-Stream VIP, used for on-chip loopback and
//   self-test without XDMA or host software.
//
//   One stimulus vector is taken on the start handshake and sent as an h2c
//   packet, most significant beat first, with tlast on the final beat. The
//   c2h response packet is then collected (first beat ends up in the most
//   significant position) into one result vector, together with a framing
//   error flag and the response latency.
//
//   Ports:
//     axi_clk, axi_aresetn        : clock, asynchronous active-low reset
//     start_valid/ready/data      : stimulus handshake, XDMA_TRANSFER_SIZE_IN bits
//     axis (master modport)       : h2c output stream, c2h input stream
//     result_valid/ready          : result handshake
//     result_data                 : collected response, XDMA_TRANSFER_SIZE_OUT bits
//     result_err                  : c2h packet too short (early tlast) or too
//                                   long (tlast missing on the final beat)
//     result_latency              : clock edges from the last h2c handshake to
//                                   the first c2h handshake, saturating
// -----------------------------------------------------------------------------
module vip_axis_host #(
  parameter int C_DATA_WIDTH           = 64,
  parameter int XDMA_TRANSFER_SIZE_IN  = 128,
  parameter int XDMA_TRANSFER_SIZE_OUT = 128
) (
  input  logic                              axi_clk,
  input  logic                              axi_aresetn,

  input  logic                              start_valid,
  output logic                              start_ready,
  input  logic [XDMA_TRANSFER_SIZE_IN-1:0]  start_data,

  vip_axis_host_if.master                   axis,

  output logic                              result_valid,
  input  logic                              result_ready,
  output logic [XDMA_TRANSFER_SIZE_OUT-1:0] result_data,
  output logic                              result_err,
  output logic [31:0]                       result_latency
);

  localparam int CW    = C_DATA_WIDTH;
  localparam int IN_W  = XDMA_TRANSFER_SIZE_IN;
  localparam int OUT_W = XDMA_TRANSFER_SIZE_OUT;
  localparam int N_IN  = IN_W / CW;
  localparam int N_OUT = OUT_W / CW;

  // Beat counters only need to reach N-1.
  localparam int TXC_W = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int RXC_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [TXC_W-1:0] TX_LAST_IDX = TXC_W'(N_IN - 1);
  localparam logic [RXC_W-1:0] RX_LAST_IDX = RXC_W'(N_OUT - 1);

  // ---------------------------------------------------------------------------
  // Parameter sanity: the vectors must be whole numbers of beats.
  // ---------------------------------------------------------------------------
  if ((IN_W % CW) != 0 || IN_W < CW) begin : g_bad_in_width
    $error("vip_axis_host: XDMA_TRANSFER_SIZE_IN must be a non-zero multiple of C_DATA_WIDTH");
  end
  if ((OUT_W % CW) != 0 || OUT_W < CW) begin : g_bad_out_width
    $error("vip_axis_host: XDMA_TRANSFER_SIZE_OUT must be a non-zero multiple of C_DATA_WIDTH");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    RECV  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state_reg;
  logic [IN_W-1:0]    tx_shift_reg;
  logic [TXC_W-1:0]   tx_cnt_reg;
  logic [OUT_W-1:0]   rx_shift_reg;
  logic [RXC_W-1:0]   rx_cnt_reg;
  logic               err_reg;
  logic [31:0]        latency_reg;
  logic               latency_frozen_reg;

  // ---------------------------------------------------------------------------
  // Handshake and helper terms
  // ---------------------------------------------------------------------------
  logic             h2c_fire;
  logic             h2c_last_beat;
  logic             c2h_fire;
  logic             rx_final_beat;
  logic [OUT_W-1:0] rx_shift_next;
  logic [31:0]      latency_inc;

  assign h2c_last_beat = (tx_cnt_reg == TX_LAST_IDX);
  assign h2c_fire      = (state_reg == SEND) && axis.m_axis_h2c_tready_0;
  assign c2h_fire      = axis.s_axis_c2h_tvalid_0 && axis.s_axis_c2h_tready_0;
  assign rx_final_beat = (rx_cnt_reg == RX_LAST_IDX);

  // Saturating increment so a response that never arrives does not wrap.
  assign latency_inc = (latency_reg == 32'hFFFF_FFFF) ? latency_reg
                                                     : latency_reg + 32'd1;

  // New c2h beat enters at the LSB end; with a single-beat result the
  // register is simply replaced.
  if (N_OUT > 1) begin : g_rx_wide
    assign rx_shift_next = {rx_shift_reg[OUT_W-CW-1:0], axis.s_axis_c2h_tdata_0};
  end else begin : g_rx_narrow
    assign rx_shift_next = axis.s_axis_c2h_tdata_0;
  end

  // ---------------------------------------------------------------------------
  // FSM and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge axi_clk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_reg          <= IDLE;
      tx_shift_reg       <= '0;
      tx_cnt_reg         <= '0;
      rx_shift_reg       <= '0;
      rx_cnt_reg         <= '0;
      err_reg            <= 1'b0;
      latency_reg        <= '0;
      latency_frozen_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_valid) begin
            tx_shift_reg <= start_data;
            tx_cnt_reg   <= '0;
            state_reg    <= SEND;
          end
        end

        SEND: begin
          if (h2c_fire) begin
            // Next beat always sits in the top CW bits.
            tx_shift_reg <= tx_shift_reg << CW;
            tx_cnt_reg   <= tx_cnt_reg + TXC_W'(1);
            if (h2c_last_beat) begin
              // Arm the receive side; the latency count starts here.
              state_reg          <= RECV;
              rx_cnt_reg         <= '0;
              rx_shift_reg       <= '0;
              err_reg            <= 1'b0;
              latency_reg        <= '0;
              latency_frozen_reg <= 1'b0;
            end
          end
        end

        RECV: begin
          // Count every edge up to and including the first c2h handshake.
          if (!latency_frozen_reg) begin
            latency_reg <= latency_inc;
            if (c2h_fire) begin
              latency_frozen_reg <= 1'b1;
            end
          end
          if (c2h_fire) begin
            rx_shift_reg <= rx_shift_next;
            rx_cnt_reg   <= rx_cnt_reg + RXC_W'(1);
            if (axis.s_axis_c2h_tlast_0) begin
              // Early tlast leaves zeros in the untouched upper beats.
              err_reg   <= !rx_final_beat;
              state_reg <= DONE;
            end else if (rx_final_beat) begin
              // Packet longer than the result: keep what we have, drop the rest.
              err_reg   <= 1'b1;
              state_reg <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (c2h_fire && axis.s_axis_c2h_tlast_0) begin
            state_reg <= DONE;
          end
        end

        DONE: begin
          if (result_ready) begin
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state only (no input-to-output paths on
  // the streams, so tvalid/tdata/tlast hold while stalled).
  // ---------------------------------------------------------------------------
  // start_ready is gated by the reset input so that it reads 0 while reset is
  // held even though the state register already sits in IDLE.
  assign start_ready = (state_reg == IDLE) && axi_aresetn;

  assign axis.m_axis_h2c_tvalid_0 = (state_reg == SEND);
  assign axis.m_axis_h2c_tdata_0  = tx_shift_reg[IN_W-1 -: CW];
  assign axis.m_axis_h2c_tlast_0  = (state_reg == SEND) && h2c_last_beat;
  assign axis.m_axis_h2c_tkeep_0  = '1;

  assign axis.s_axis_c2h_tready_0 = (state_reg == RECV) || (state_reg == DRAIN);

  assign result_valid   = (state_reg == DONE);
  assign result_data    = rx_shift_reg;
  assign result_err     = err_reg;
  assign result_latency = latency_reg;

  // c2h tkeep carries no information for this block.
  logic unused_c2h_tkeep;
  assign unused_c2h_tkeep = ^axis.s_axis_c2h_tkeep_0;

endmodule

// File: doc/vip_axis_host.md
# vip_axis_host

Host-side counterpart of the DUT-wrapping AXI-Stream VIP. It serializes one wide stimulus vector into an h2c AXI-Stream packet, MSB beat first, with `tlast` on the final beat. It then collects the c2h response packet into one wide result vector and reports framing errors and response latency. It is used for on-chip loopback and self-test of the VIP without XDMA/host software, and sits between a local stimulus source/checker and the VIP's h2c/c2h ports.

## Interface
- `C_DATA_WIDTH`, 64, AXI-Stream data width in bits.
- `XDMA_TRANSFER_SIZE_IN`, 128, stimulus vector width in bits. Must be a multiple of `C_DATA_WIDTH`, otherwise elaboration fails.
- `XDMA_TRANSFER_SIZE_OUT`, 128, result vector width in bits. Must be a multiple of `C_DATA_WIDTH`, otherwise elaboration fails.
- Derived: `N_IN = XDMA_TRANSFER_SIZE_IN/C_DATA_WIDTH` and `N_OUT = XDMA_TRANSFER_SIZE_OUT/C_DATA_WIDTH`, each ≥1.

Clock and reset: one clock; reset is asynchronous and active-low.
- `axi_clk` in 1: the single clock.
- `axi_aresetn` in 1: asynchronous, active-low reset.

Ports:
- `start_valid` in 1: stimulus offer.
- `start_ready` out 1: block can accept a stimulus.
- `start_data` in XDMA_TRANSFER_SIZE_IN: stimulus vector.
- `m_axis_h2c_tdata_0` out C_DATA_WIDTH: h2c beat data.
- `m_axis_h2c_tlast_0` out 1: final h2c beat.
- `m_axis_h2c_tvalid_0` out 1: h2c beat valid.
- `m_axis_h2c_tready_0` in 1: VIP accepts h2c beat.
- `m_axis_h2c_tkeep_0` out C_DATA_WIDTH/8: always all ones.
- `s_axis_c2h_tdata_0` in C_DATA_WIDTH: c2h beat data.
- `s_axis_c2h_tlast_0` in 1: final c2h beat.
- `s_axis_c2h_tvalid_0` in 1: c2h beat valid.
- `s_axis_c2h_tready_0` out 1: block accepts c2h beat.
- `s_axis_c2h_tkeep_0` in C_DATA_WIDTH/8: ignored.
- `result_valid` out 1: result available.
- `result_ready` in 1: consumer takes result.
- `result_data` out XDMA_TRANSFER_SIZE_OUT: collected response.
- `result_err` out 1: c2h framing error for this result.
- `result_latency` out 32: cycles from last h2c handshake to first c2h handshake.

## Operation
- FSM states: IDLE, SEND, RECV, DRAIN, DONE. Reset state is IDLE.
- `start_ready = (state==IDLE)`.
- IDLE → SEND on start handshake. On that handshake, `start_data` loads the tx shift register and the tx beat counter is cleared.
- SEND:
  - `h2c_tvalid=1`, `h2c_tdata = txreg[IN-1 -: C_DATA_WIDTH]`.
  - `h2c_tlast = (tx_cnt==N_IN-1)`.
  - On each handshake: shift `txreg` left by `C_DATA_WIDTH`, `tx_cnt++`.
  - The handshake with `tlast` moves the FSM to RECV. `rx_cnt`, `rxreg`, `err` and the latency counter are cleared.
- RECV:
  - `c2h_tready=1`.
  - On each c2h handshake: `rxreg = {rxreg[OUT-C_DATA_WIDTH-1:0], tdata}` (shift left, new beat at LSB); `rx_cnt++`.
  - `tlast` with `rx_cnt==N_OUT-1`: go to DONE, `err=0`.
  - `tlast` with `rx_cnt<N_OUT-1` (early): go to DONE, `err=1`. `result_data` is the partially shifted register; the upper bits are zero.
  - Beat `N_OUT-1` without `tlast` (missing): `err=1`, go to DRAIN. `result_data` holds the `N_OUT` beats.
- DRAIN: `c2h_tready=1`. Beats are discarded without shifting. The handshake with `tlast` moves the FSM to DONE.
- DONE:
  - `result_valid=1`; `result_data`, `result_err` and `result_latency` are stable.
  - `result_ready` moves the FSM to IDLE.
- Latency counter:
  - Loaded with 0 on the last h2c handshake.
  - Increments on every clock edge in RECV up to and including the edge of the first c2h handshake, then freezes.
  - Saturates at 2^32-1.
- `c2h_tready=0` in IDLE, SEND and DONE. Any c2h beat outside RECV/DRAIN stalls and is not consumed.

## Timing
- Reset values while `axi_aresetn=0`: all outputs are 0, except `h2c_tkeep` which is all ones. All registers clear asynchronously.
- `start_ready` is 0 during reset and 1 in the first cycle after deassertion.
- Reset asserted mid-operation abandons the transfer immediately (asynchronously) and returns the FSM to IDLE. No partial result is reported.
- Start handshake at edge t: first h2c beat is valid in cycle t+1.
- With `h2c_tready` held at 1, a packet occupies exactly `N_IN` cycles.
- AXI-S rule: once `h2c_tvalid=1`, the outputs `tvalid`, `tdata` and `tlast` hold stable until the handshake.
- First c2h beat can be accepted in the cycle after the last h2c handshake.
- Final c2h handshake at edge t: `result_valid=1` from cycle t+1.
- `result_ready` at edge t: `start_ready=1` in cycle t+1. A new start can therefore be accepted 1 cycle after a result is taken.
- `N_IN==1` or `N_OUT==1`: single-beat packets; `tlast` is on beat 0.

## Test plan
- Basic (CW=64, IN=OUT=128):
  - Stimulus: start `0x00112233445566778899AABBCCDDEEFF`.
  - Required h2c beats: `0x0011223344556677`, then `0x8899AABBCCDDEEFF` with `tlast`.
  - Drive c2h beats `0xA`, then `0xB` with `tlast`.
  - Required result: `result_data = {64'hA, 64'hB}`, `err=0`.
- h2c backpressure: toggle `h2c_tready` in the pattern 0,1,0,0,1. Required: `tdata`/`tlast` stable while stalled, exactly 2 beats, correct order.
- Early `tlast`: first c2h beat `0x5` with `tlast`. Required: `result_data = {64'h0, 64'h5}`, `err=1`.
- Missing `tlast`: c2h beats `0x1`, `0x2`, then `0x3` with `tlast`. Required: `result_data = {1, 2}`, `err=1`, `0x3` drained, `result_valid` asserted after the third beat.
- Latency: first c2h handshake 5 edges after the last h2c handshake. Required: `result_latency=5`. Hold `result_ready=0` for 10 cycles; required: result stable throughout.
- Reset mid-SEND: assert `axi_aresetn=0` after the first h2c beat. Required: outputs zero immediately, IDLE after release, next start produces a correct full packet.
